// File: rtl/lzrw1_compressor_if.sv
// Byte-in / item-out bundle for lzrw1_compressor.
//   in_byte/in_valid/in_last/in_ready : uncompressed byte stream (valid/ready)
//   data_out/control_word_out/out_valid/out_busy : item stream toward the decompressor
//   done : one-cycle pulse after the item holding the final byte is transferred
// slave  = compressor side, master = producer/consumer side.
interface lzrw1_compressor_if;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [15:0] data_out;
    logic        control_word_out;
    logic        out_valid;
    logic        out_busy;
    logic        done;

    modport slave (
        input  in_byte, in_valid, in_last, out_busy,
        output in_ready, data_out, control_word_out, out_valid, done
    );

    modport master (
        output in_byte, in_valid, in_last, out_busy,
        input  in_ready, data_out, control_word_out, out_valid, done
    );
endinterface

// File: rtl/lzrw1_compressor.sv
// Streaming LZRW1-style compressor.
// Bytes are written into a ring history buffer; a hash of the 3 bytes at
// head selects one earlier position as a match candidate, which is verified
// byte by byte before a copy item is emitted. Items are literals
// ({8'h00, byte}, control 0) or copies ({len-3, offset}, control 1).
// Ports:
//   i_clock   : rising-edge clock
//   i_reset_n : asynchronous active-low reset
//   bus       : lzrw1_compressor_if.slave (byte input and item output)
//
// state   | meaning
// FILL    | wait for a full lookahead window or end of stream
// HASH    | read candidate from hash table, record head in its slot
// CHECK   | accept candidate only if its distance lies inside the window
// MATCH   | compare candidate and head bytes, one byte per cycle
// LIT     | form a literal from the byte at head
// EMIT    | hold item on the output until the consumer takes it
// DONE    | forget the finished stream (hash valids, pointers, eos)
module lzrw1_compressor #(
    parameter int HISTORY_SIZE = 256,
    parameter int HASH_BITS    = 8,
    parameter int MAX_MATCH    = 18,
    parameter int MIN_MATCH    = 3,
    parameter int POS_WIDTH    = 16
) (
    input  logic                i_clock,
    input  logic                i_reset_n,
    lzrw1_compressor_if.slave   bus
);

    localparam int HA = $clog2(HISTORY_SIZE);
    localparam int HT = 1 << HASH_BITS;
    localparam int LW = 5;

    localparam logic [POS_WIDTH-1:0] P_ONE = POS_WIDTH'(1);
    localparam logic [POS_WIDTH-1:0] P_MAX = POS_WIDTH'(MAX_MATCH);
    localparam logic [POS_WIDTH-1:0] P_MIN = POS_WIDTH'(MIN_MATCH);
    localparam logic [POS_WIDTH-1:0] P_WIN = POS_WIDTH'(HISTORY_SIZE - MAX_MATCH);

    localparam logic [2:0] S_FILL  = 3'd0;
    localparam logic [2:0] S_HASH  = 3'd1;
    localparam logic [2:0] S_CHECK = 3'd2;
    localparam logic [2:0] S_MATCH = 3'd3;
    localparam logic [2:0] S_LIT   = 3'd4;
    localparam logic [2:0] S_EMIT  = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    logic [7:0]           r_buf [HISTORY_SIZE];
    logic [POS_WIDTH-1:0] r_tab [HT];
    logic [HT-1:0]        r_tab_vld;
    logic [POS_WIDTH-1:0] r_head;
    logic [POS_WIDTH-1:0] r_tail;
    logic [POS_WIDTH-1:0] r_cand;
    logic                 r_cand_vld;
    logic                 r_eos;
    logic                 r_run;
    logic [2:0]           r_state;
    logic [LW-1:0]        r_k;
    logic [LW-1:0]        r_len;
    logic [15:0]          r_data;
    logic                 r_ctrl;
    logic                 r_out_valid;
    logic                 r_done;

    logic [POS_WIDTH-1:0] w_look;
    logic [POS_WIDTH-1:0] w_off;
    logic [POS_WIDTH-1:0] w_kp;
    logic [POS_WIDTH-1:0] w_head_next;
    logic [HA-1:0]        w_h0;
    logic [HA-1:0]        w_h1;
    logic [HA-1:0]        w_h2;
    logic [HA-1:0]        w_mc;
    logic [HA-1:0]        w_mh;
    logic [7:0]           w_b0;
    logic [7:0]           w_b1;
    logic [7:0]           w_b2;
    logic [HASH_BITS-1:0] w_hash;
    logic                 w_in_ready;
    logic                 w_accept;
    logic                 w_off_ok;
    logic                 w_stop;
    logic                 w_xfer;

    assign w_look      = r_tail - r_head;
    assign w_off       = r_head - r_cand;
    assign w_kp        = POS_WIDTH'(r_k);
    assign w_head_next = r_head + POS_WIDTH'(r_len);

    assign w_h0 = r_head[HA-1:0];
    assign w_h1 = w_h0 + HA'(1);
    assign w_h2 = w_h0 + HA'(2);
    assign w_b0 = r_buf[w_h0];
    assign w_b1 = r_buf[w_h1];
    assign w_b2 = r_buf[w_h2];
    assign w_hash = HASH_BITS'({w_b0, 4'h0} ^ {2'b00, w_b1, 2'b00} ^ {4'h0, w_b2});

    // r_run keeps in_ready low while reset is held and for the first cycle after
    assign w_in_ready = r_run & (w_look < P_MAX) & ~r_eos & (r_state != S_DONE);
    assign w_accept   = bus.in_valid & w_in_ready;
    assign w_off_ok   = r_cand_vld & (w_off != '0) & (w_off <= P_WIN);

    // candidate and head walk together; overlap (off < len) reads bytes
    // already verified earlier in this same match, so it needs no special case
    assign w_mc   = r_cand[HA-1:0] + HA'(r_k);
    assign w_mh   = w_h0 + HA'(r_k);
    assign w_stop = (r_k == LW'(MAX_MATCH)) | (w_kp == w_look) | (r_buf[w_mc] != r_buf[w_mh]);
    assign w_xfer = r_out_valid & ~bus.out_busy;

    assign bus.in_ready         = w_in_ready;
    assign bus.data_out         = r_data;
    assign bus.control_word_out = r_ctrl;
    assign bus.out_valid        = r_out_valid;
    assign bus.done             = r_done;

    always_ff @(posedge i_clock) begin
        if (w_accept) begin
            r_buf[r_tail[HA-1:0]] <= bus.in_byte;
        end
    end

    always_ff @(posedge i_clock) begin
        if (r_state == S_HASH) begin
            r_tab[w_hash] <= r_head;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_tab_vld   <= '0;
            r_head      <= '0;
            r_tail      <= '0;
            r_cand      <= '0;
            r_cand_vld  <= 1'b0;
            r_eos       <= 1'b0;
            r_run       <= 1'b0;
            r_state     <= S_FILL;
            r_k         <= '0;
            r_len       <= '0;
            r_data      <= '0;
            r_ctrl      <= 1'b0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_run  <= 1'b1;
            r_done <= 1'b0;
            if (w_accept) begin
                r_tail <= r_tail + P_ONE;
                if (bus.in_last) begin
                    r_eos <= 1'b1;
                end
            end
            case (r_state)
                S_FILL: begin
                    if ((w_look >= P_MAX) || (r_eos && (w_look != '0))) begin
                        r_state <= (w_look < P_MIN) ? S_LIT : S_HASH;
                    end
                end
                S_HASH: begin
                    r_cand            <= r_tab[w_hash];
                    r_cand_vld        <= r_tab_vld[w_hash];
                    r_tab_vld[w_hash] <= 1'b1;
                    r_state           <= S_CHECK;
                end
                S_CHECK: begin
                    r_k     <= '0;
                    r_state <= w_off_ok ? S_MATCH : S_LIT;
                end
                S_MATCH: begin
                    if (!w_stop) begin
                        r_k <= r_k + LW'(1);
                    end else if (r_k >= LW'(MIN_MATCH)) begin
                        r_data      <= {4'(r_k - LW'(MIN_MATCH)), w_off[11:0]};
                        r_ctrl      <= 1'b1;
                        r_len       <= r_k;
                        r_out_valid <= 1'b1;
                        r_state     <= S_EMIT;
                    end else begin
                        r_state <= S_LIT;
                    end
                end
                S_LIT: begin
                    r_data      <= {8'h00, w_b0};
                    r_ctrl      <= 1'b0;
                    r_len       <= LW'(1);
                    r_out_valid <= 1'b1;
                    r_state     <= S_EMIT;
                end
                S_EMIT: begin
                    if (w_xfer) begin
                        r_out_valid <= 1'b0;
                        r_head      <= w_head_next;
                        // no byte can arrive once eos is set, so tail is final here
                        if (r_eos && (w_head_next == r_tail)) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_FILL;
                        end
                    end
                end
                S_DONE: begin
                    r_tab_vld <= '0;
                    r_eos     <= 1'b0;
                    r_head    <= '0;
                    r_tail    <= '0;
                    r_state   <= S_FILL;
                end
                default: begin
                    r_state <= S_FILL;
                end
            endcase
        end
    end

endmodule
